// File: rtl/uart_pkg.sv
// Shared types and baud helpers for the UART core and its FIFOs.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  function automatic int baud_div(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

  function automatic int baud_cnt_w(input int div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with full/empty status; DEPTH must be a power of two.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_valid_i,
  output logic             full_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  input  logic             rd_ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign pop     = rd_ready_i && !empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign push    = wr_valid_i && (!full_o || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: TX FIFO -> frame serialiser, synchronised RX deserialiser -> RX FIFO.
module uart_core
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ   = 100000000,
  parameter int      BAUDRATE   = 115200,
  parameter int      DATA_BITS  = 8,
  parameter parity_e PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 tx_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_frame_err_o,
  output logic                 rx_overrun_o
);

  localparam int               BAUD_DIV   = baud_div(CLK_FREQ, BAUDRATE);
  localparam int               CNT_W      = baud_cnt_w(BAUD_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [2:0]       DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic             ODD_INV    = (PARITY == PAR_ODD);
  localparam bit               HAS_PARITY = (PARITY != PAR_NONE);

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ ODD_INV;
  endfunction

  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_fifo_data;
  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_baud_q, tx_baud_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_bit_end;

  logic                 rx_full, rx_empty, rx_push;
  logic [DATA_BITS:0]   rx_head;
  logic                 rx_sync_p0, rx_sync_p1;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_baud_q, rx_baud_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_bit_end;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_data_i  (tx_data_i),
    .wr_valid_i (tx_valid_i && !tx_full),
    .full_o     (tx_full),
    .rd_data_o  (tx_fifo_data),
    .empty_o    (tx_empty),
    .rd_ready_i (tx_pop)
  );

  uart_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_data_i  ({rx_perr_q, rx_shift_q}),
    .wr_valid_i (rx_push),
    .full_o     (rx_full),
    .rd_data_o  (rx_head),
    .empty_o    (rx_empty),
    .rd_ready_i (rx_ready_i)
  );

  assign tx_ready_o      = !tx_full;
  assign tx_busy_o       = (tx_state_q != TX_IDLE) || !tx_empty;
  assign tx_o            = tx_line_q;
  assign rx_valid_o      = !rx_empty;
  assign rx_data_o       = rx_head[DATA_BITS-1:0];
  assign rx_parity_err_o = rx_head[DATA_BITS];
  assign rx_frame_err_o  = frame_err_q;
  assign rx_overrun_o    = overrun_q;

  // ---- TX: the line level is registered together with the state that produces it
  assign tx_bit_end = (tx_baud_q == BIT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_bit_end ? '0 : tx_baud_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_baud_d = '0;
        tx_line_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_bit_d   = '0;
        tx_line_d  = tx_shift_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == DATA_LAST) begin
          tx_bit_d = '0;
          if (HAS_PARITY) begin
            tx_line_d  = tx_par_q;
            tx_state_d = TX_PARITY;
          end else begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end
        end else begin
          tx_bit_d  = tx_bit_q + 3'd1;
          tx_line_d = tx_shift_q[1];
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_bit_d   = '0;
        tx_line_d  = 1'b1;
        tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit_q == STOP_LAST) begin
          // Chain straight into the next start bit so queued bytes leave without a gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_line_d  = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_pop) begin
      tx_shift_d = tx_fifo_data;
      tx_par_d   = parity_bit(tx_fifo_data);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_ff @(posedge clk_i) begin
    tx_shift_q <= tx_shift_d;
    tx_par_q   <= tx_par_d;
  end

  // ---- RX: two-flop synchroniser, then centre-of-bit sampling
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_i;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rx_bit_end = (rx_baud_q == BIT_LAST);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_baud_d   = rx_bit_end ? '0 : rx_baud_q + CNT_W'(1);
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_perr_d   = rx_perr_q;
    rx_push     = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_baud_d = '0;
        if (!rx_sync_p1) begin
          rx_perr_d  = 1'b0;
          rx_state_d = RX_START;
        end
      end
      RX_START: if (rx_baud_q == HALF_LAST) begin
        rx_baud_d  = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_p1 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_shift_d = {rx_sync_p1, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == DATA_LAST) rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
        else                       rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_PARITY: if (rx_bit_end) begin
        rx_perr_d  = (rx_sync_p1 != parity_bit(rx_shift_q));
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_bit_end) begin
        if (rx_sync_p1) begin
          rx_push    = 1'b1;
          overrun_d  = rx_full && !rx_ready_i;
          rx_state_d = RX_IDLE;
        end else begin
          frame_err_d = 1'b1;
          rx_state_d  = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        rx_baud_d = '0;
        if (rx_sync_p1) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q  <= RX_IDLE;
      rx_baud_q   <= '0;
      rx_bit_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_baud_q   <= rx_baud_d;
      rx_bit_q    <= rx_bit_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rx_shift_q <= rx_shift_d;
    rx_perr_q  <= rx_perr_d;
  end

endmodule

// File: tb/tb_uart_core.sv
// Randomised bench for uart_core: TX waveforms and RX results compared with a bit-level frame model.
module tb_uart_core;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUDRATE = 62500;
  localparam int BIT_CYC  = CLK_FREQ / BAUDRATE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // 8N1, depth 4: bench drives ser_a
  logic       ser_a = 1'b1, txv_a = 1'b0, rxr_a = 1'b0;
  logic [7:0] txd_a = '0;
  logic       tx_a, txr_a, busy_a, pe_a, rxv_a, fe_a, ov_a;
  logic [7:0] rxd_a;
  // 8E2 with tx looped back to rx
  logic       txv_b = 1'b0;
  logic [7:0] txd_b = '0;
  logic       tx_b, txr_b, busy_b, pe_b, rxv_b, fe_b, ov_b;
  logic [7:0] rxd_b;
  // 7O1 receiver: bench drives ser_c
  logic       ser_c = 1'b1, rxr_c = 1'b0;
  logic       tx_c, txr_c, busy_c, pe_c, rxv_c, fe_c, ov_c;
  logic [6:0] rxd_c;

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE)) u_8n1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(ser_a), .tx_o(tx_a),
    .tx_data_i(txd_a), .tx_valid_i(txv_a), .tx_ready_o(txr_a), .tx_busy_o(busy_a),
    .rx_data_o(rxd_a), .rx_parity_err_o(pe_a), .rx_valid_o(rxv_a), .rx_ready_i(rxr_a),
    .rx_frame_err_o(fe_a), .rx_overrun_o(ov_a));

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_8e2 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(tx_b), .tx_o(tx_b),
    .tx_data_i(txd_b), .tx_valid_i(txv_b), .tx_ready_o(txr_b), .tx_busy_o(busy_b),
    .rx_data_o(rxd_b), .rx_parity_err_o(pe_b), .rx_valid_o(rxv_b), .rx_ready_i(1'b1),
    .rx_frame_err_o(fe_b), .rx_overrun_o(ov_b));

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE), .DATA_BITS(7), .PARITY(PAR_ODD)) u_7o1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(ser_c), .tx_o(tx_c),
    .tx_data_i(7'h00), .tx_valid_i(1'b0), .tx_ready_o(txr_c), .tx_busy_o(busy_c),
    .rx_data_o(rxd_c), .rx_parity_err_o(pe_c), .rx_valid_o(rxv_c), .rx_ready_i(rxr_c),
    .rx_frame_err_o(fe_c), .rx_overrun_o(ov_c));

  int         fe_cnt_a = 0, ov_cnt_a = 0, fe_cnt_c = 0, err_cnt_b = 0;
  logic [8:0] q_b[$];

  always @(negedge clk) begin
    if (fe_a) fe_cnt_a <= fe_cnt_a + 1;
    if (ov_a) ov_cnt_a <= ov_cnt_a + 1;
    if (fe_c) fe_cnt_c <= fe_cnt_c + 1;
    if (fe_b || ov_b) err_cnt_b <= err_cnt_b + 1;
    if (rxv_b) q_b.push_back({pe_b, rxd_b});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame as a bit list, index 0 = first on the line.
  function automatic logic [15:0] frame(input logic [7:0] d, input int nb, input parity_e par,
                                        input int ns, output int len);
    logic [15:0] f;
    int ones, p;
    f = '1; ones = 0; p = 1;
    f[0] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f[p] = d[i];
      ones += int'(d[i]);
      p++;
    end
    if (par == PAR_EVEN) begin f[p] = ((ones % 2) == 1); p++; end
    if (par == PAR_ODD)  begin f[p] = ((ones % 2) == 0); p++; end
    for (int i = 0; i < ns; i++) begin f[p] = 1'b1; p++; end
    len = p;
    return f;
  endfunction

  task automatic drive(input int which, input logic [15:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      if (which == 0) ser_a = f[i];
      else            ser_c = f[i];
      tick(BIT_CYC);
    end
  endtask

  task automatic tx_wave(input int which, input logic [15:0] f, input int len, input string tag);
    int   bad;
    logic cur;
    for (int b = 0; b < len; b++) begin
      bad = 0;
      for (int c = 0; c < BIT_CYC; c++) begin
        cur = (which == 0) ? tx_a : tx_b;
        if (cur !== f[b]) bad++;
        tick();
      end
      chk($sformatf("%s_bit%0d", tag, b), 32'(bad), 32'd0);
    end
  endtask

  task automatic wait_rxv(input int which, input int budget, input string tag);
    int t;
    t = 0;
    while ((((which == 0) ? rxv_a : rxv_c) !== 1'b1) && t < budget) begin
      tick();
      t++;
    end
    chk(tag, 32'(t < budget), 32'd1);
  endtask

  task automatic watch(input int n, output int rxv_hits, output int txlow_hits);
    rxv_hits = 0;
    txlow_hits = 0;
    for (int i = 0; i < n; i++) begin
      if (rxv_a !== 1'b0) rxv_hits++;
      if (tx_a !== 1'b1) txlow_hits++;
      tick();
    end
  endtask

  task automatic pop_a(input logic [7:0] exp, input string tag);
    chk({tag, "_valid"}, 32'(rxv_a), 32'd1);
    chk(tag, 32'(rxd_a), 32'(exp));
    rxr_a = 1'b1;
    tick();
    rxr_a = 1'b0;
  endtask

  task automatic tx_one(input logic [7:0] d);
    logic [15:0] f;
    int len;
    f = frame(d, 8, PAR_NONE, 1, len);
    txd_a = d;
    txv_a = 1'b1;
    chk("tx_ready_a", 32'(txr_a), 32'd1);
    tick();
    txv_a = 1'b0;
    chk("tx_n1_high", 32'(tx_a), 32'd1);
    chk("tx_n1_busy", 32'(busy_a), 32'd1);
    tick();
    tx_wave(0, f, len, $sformatf("tx8n1_%02h", d));
    chk("tx_end_high", 32'(tx_a), 32'd1);
    chk("tx_end_busy", 32'(busy_a), 32'd0);
  endtask

  task automatic lb_round(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0]  bs[3];
    logic [15:0] f;
    int len, base, t;
    bs = '{b0, b1, b2};
    base = q_b.size();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          txd_b = bs[i];
          txv_b = 1'b1;
          chk("lb_tx_ready", 32'(txr_b), 32'd1);
          tick();
        end
        txv_b = 1'b0;
      end
      begin
        tick(2);
        for (int i = 0; i < 3; i++) begin
          f = frame(bs[i], 8, PAR_EVEN, 2, len);
          tx_wave(1, f, len, $sformatf("tx8e2_%02h", bs[i]));
        end
      end
    join
    t = 0;
    while (q_b.size() < base + 3 && t < 200) begin
      tick();
      t++;
    end
    chk("lb_rx_count", 32'(q_b.size() >= base + 3), 32'd1);
    for (int i = 0; i < 3; i++)
      if (q_b.size() > base + i) chk($sformatf("lb_rx%0d", i), 32'(q_b[base + i]), 32'({1'b0, bs[i]}));
    chk("lb_idle_busy", 32'(busy_b), 32'd0);
  endtask

  initial begin
    logic [15:0] f;
    logic [7:0]  r;
    logic [6:0]  r7;
    int len, fe0, ov0, h_rx, h_tx;

    tick(3);
    chk("rst_tx_o", 32'(tx_a), 32'd1);
    chk("rst_tx_ready", 32'(txr_a), 32'd1);
    chk("rst_tx_busy", 32'(busy_a), 32'd0);
    chk("rst_rx_valid", 32'(rxv_a), 32'd0);
    chk("rst_rx_data", 32'(rxd_a), 32'd0);
    chk("rst_rx_perr", 32'(pe_a), 32'd0);
    chk("rst_frame_err", 32'(fe_a), 32'd0);
    chk("rst_overrun", 32'(ov_a), 32'd0);
    chk("rst_other", 32'({tx_b, txr_b, busy_b, tx_c, txr_c, busy_c, rxv_c, pe_c, fe_c, ov_c}),
        32'(10'b1101100000));
    rst_n = 1'b1;
    tick(4);

    // TX waveform, 8N1
    tx_one(8'h56);
    for (int i = 0; i < 2; i++) tx_one(8'($urandom));

    // loopback 8E2, back-to-back frames
    lb_round(8'hA5, 8'h00, 8'hFF);
    lb_round(8'($urandom), 8'($urandom), 8'($urandom));
    chk("lb_no_errors", 32'(err_cnt_b), 32'd0);

    // 7O1 receive: inverted parity, then a clean random byte
    f = frame(8'h41, 7, PAR_ODD, 1, len);
    f[8] = ~f[8];
    drive(1, f, len);
    wait_rxv(1, 100, "rx7o1_wait");
    chk("rx7o1_data", 32'(rxd_c), 32'h41);
    chk("rx7o1_perr", 32'(pe_c), 32'd1);
    rxr_c = 1'b1; tick(); rxr_c = 1'b0;
    chk("rx7o1_popped", 32'(rxv_c), 32'd0);
    r7 = 7'($urandom);
    f = frame({1'b0, r7}, 7, PAR_ODD, 1, len);
    drive(1, f, len);
    wait_rxv(1, 100, "rx7o1_wait2");
    chk("rx7o1_data2", 32'(rxd_c), 32'(r7));
    chk("rx7o1_perr2", 32'(pe_c), 32'd0);
    rxr_c = 1'b1; tick(); rxr_c = 1'b0;
    chk("rx7o1_no_ferr", 32'(fe_cnt_c), 32'd0);

    // framing error followed by a held-low line
    fe0 = fe_cnt_a;
    f = frame(8'h33, 8, PAR_NONE, 1, len);
    f[9] = 1'b0;
    drive(0, f, len);
    tick(40);
    ser_a = 1'b1;
    watch(300, h_rx, h_tx);
    chk("ferr_pulses", 32'(fe_cnt_a - fe0), 32'd1);
    chk("ferr_no_push", 32'(h_rx), 32'd0);
    r = 8'($urandom);
    f = frame(r, 8, PAR_NONE, 1, len);
    drive(0, f, len);
    wait_rxv(0, 100, "after_ferr_wait");
    pop_a(r, "after_ferr_data");

    // overrun on the fifth frame into a depth-4 FIFO
    ov0 = ov_cnt_a;
    for (int i = 1; i <= 5; i++) begin
      f = frame(8'(i), 8, PAR_NONE, 1, len);
      drive(0, f, len);
      if (i == 4) chk("ovr_before5", 32'(ov_cnt_a - ov0), 32'd0);
    end
    tick(4);
    chk("ovr_pulses", 32'(ov_cnt_a - ov0), 32'd1);
    for (int i = 1; i <= 4; i++) pop_a(8'(i), $sformatf("ovr_pop%0d", i));
    chk("ovr_drained", 32'(rxv_a), 32'd0);

    // short glitch on an idle line
    fe0 = fe_cnt_a;
    ser_a = 1'b0;
    tick(8);
    ser_a = 1'b1;
    watch(300, h_rx, h_tx);
    chk("glitch_no_frame", 32'(h_rx), 32'd0);
    chk("glitch_no_ferr", 32'(fe_cnt_a - fe0), 32'd0);

    // asynchronous reset in the middle of a data bit
    txd_a = 8'h00;
    txv_a = 1'b1;
    tick();
    txv_a = 1'b0;
    tick(1 + BIT_CYC + 2 * BIT_CYC + BIT_CYC / 2);
    chk("pre_rst_tx_low", 32'(tx_a), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_o", 32'(tx_a), 32'd1);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_ready", 32'(txr_a), 32'd1);
    tick(2);
    rst_n = 1'b1;
    watch(200, h_rx, h_tx);
    chk("post_rst_tx_idle", 32'(h_tx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
